// File: rtl/ofs_emif_avmm_bridge.sv
// ofs_emif_avmm_bridge: 512-bit upstream AVMM to 576-bit EMIF AVMM bridge.
// A 2-entry command FIFO keeps m_waitrequest off the upstream stall path.
// A read-beat credit counter bounds outstanding read data.
// Optional ECC-lane byte parity (fill and check): define OFS_EMIF_BRIDGE_PARITY_EN.
module ofs_emif_avmm_bridge #(
  parameter int MAX_RD_BEATS = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [26:0]  u_address,
  input  logic         u_read,
  input  logic         u_write,
  input  logic [511:0] u_writedata,
  input  logic [63:0]  u_byteenable,
  input  logic [6:0]   u_burstcount,
  output logic         u_waitrequest,
  output logic [511:0] u_readdata,
  output logic         u_readdatavalid,
  output logic [26:0]  m_address,
  output logic         m_read,
  output logic         m_write,
  output logic [575:0] m_writedata,
  output logic [71:0]  m_byteenable,
  output logic [6:0]   m_burstcount,
  input  logic         m_waitrequest,
  input  logic [575:0] m_readdata,
  input  logic         m_readdatavalid,
  output logic         ecc_err,
  output logic         rd_unexp
);

  localparam int CW = $clog2(MAX_RD_BEATS + 1);
  localparam int SW = CW + 1;

  typedef struct packed {
    logic [26:0]  addr;
    logic         rd;
    logic         wr;
    logic [511:0] data;
    logic [63:0]  be;
    logic [6:0]   bc;
  } cmd_t;

  cmd_t            fifo_mem [2];
  cmd_t            head;
  logic            wp, rp;
  logic [1:0]      cnt;
  logic            valid, push, pop, credit_short;
  logic [CW-1:0]   rd_out;
  logic [6:0]      wr_left;
  logic [SW-1:0]   rd_sum;
  logic [63:0]     wr_ecc;
  logic [7:0]      be_ecc;

  // Stall only from registered state, so m_waitrequest never reaches upstream.
  assign rd_sum        = SW'(rd_out) + SW'(u_burstcount);
  assign credit_short  = rd_sum > SW'(MAX_RD_BEATS);
  assign u_waitrequest = rst | (cnt == 2'd2) |
                         (u_read & (credit_short | (wr_left != 7'd0)));
  assign push          = (u_read | u_write) & ~u_waitrequest;

  assign valid = cnt != 2'd0;
  assign head  = fifo_mem[rp];
  assign pop   = (m_read | m_write) & ~m_waitrequest;

  // FIFO head drives the EMIF port; everything reads as zero when empty.
  assign m_read       = valid & head.rd;
  assign m_write      = valid & head.wr;
  assign m_address    = valid ? head.addr : '0;
  assign m_burstcount = valid ? head.bc : '0;
  assign m_writedata  = valid ? {wr_ecc, head.data} : '0;
  assign m_byteenable = valid ? {be_ecc, head.be} : '0;

  // Command storage needs no reset; outputs are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wp] <= '{addr: u_address, rd: u_read, wr: u_write,
                                data: u_writedata, be: u_byteenable, bc: u_burstcount};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Remaining beats of the current write burst; reads wait until it is done.
  always_ff @(posedge clk) begin
    if (rst) wr_left <= 7'd0;
    else if (push && u_write)
      wr_left <= (wr_left == 7'd0) ? u_burstcount - 7'd1 : wr_left - 7'd1;
  end

  // Read credits: add the burst on accept, retire one per returned beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_out   <= '0;
      rd_unexp <= 1'b0;
    end else begin
      rd_out <= rd_out + ((push && u_read) ? CW'(u_burstcount) : CW'(0))
                       - ((m_readdatavalid && rd_out != '0) ? CW'(1) : CW'(0));
      if (m_readdatavalid && rd_out == '0) rd_unexp <= 1'b1;
    end
  end

  // Read return path, one register stage, never stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      u_readdata      <= '0;
      u_readdatavalid <= 1'b0;
    end else begin
      u_readdata      <= m_readdata[511:0];
      u_readdatavalid <= m_readdatavalid;
    end
  end

`ifdef OFS_EMIF_BRIDGE_PARITY_EN
  // Bit 8w+b of the lane is the parity of byte b of 64-bit word w.
  function automatic logic [63:0] byte_par(input logic [511:0] d);
    logic [63:0] p;
    for (int i = 0; i < 64; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  assign wr_ecc = byte_par(head.data);
  always_comb begin
    be_ecc = '0;
    for (int w = 0; w < 8; w++) be_ecc[w] = |head.be[8*w +: 8];
  end

  // Sticky lane mismatch, raised together with the matching u_readdatavalid.
  always_ff @(posedge clk) begin
    if (rst) ecc_err <= 1'b0;
    else if (m_readdatavalid && byte_par(m_readdata[511:0]) != m_readdata[575:512])
      ecc_err <= 1'b1;
  end
`else
  logic unused_ecc_lane;
  assign unused_ecc_lane = ^m_readdata[575:512];
  assign wr_ecc  = '0;
  assign be_ecc  = '0;
  assign ecc_err = 1'b0;
`endif

  // A first beat (any read, or a write outside a burst) must carry a real length.
  a_bc_nonzero: assert property (@(posedge clk) disable iff (rst)
    (push && (u_read || wr_left == 7'd0)) |-> (u_burstcount != 7'd0));

endmodule
